// File: rtl/mac_rr_scheduler.sv
// Round-robin front end that time-shares one pipelined multiply-add unit between
// N_REQ requesters and routes each result back to its owner as a one-hot strobe.

module mac_rr_lane #(
   parameter int SIZE_REG = 8,
   parameter int IDW      = 2,
   parameter int IDX      = 0
) (
   input  logic                found,
   input  logic [IDW-1:0]      gnt_id,
   input  logic [SIZE_REG-1:0] a,
   input  logic [SIZE_REG-1:0] b,
   input  logic [SIZE_REG-1:0] c,
   input  logic                tag_vld,
   input  logic [IDW-1:0]      tag_id,
   output logic                ready,
   output logic [SIZE_REG-1:0] a_m,
   output logic [SIZE_REG-1:0] b_m,
   output logic [SIZE_REG-1:0] c_m,
   output logic                rsp_hit
);
   localparam logic [IDW-1:0] ID = IDW'(IDX);

   assign ready   = found && (gnt_id == ID);
   // AND-OR operand mux slice: only the granted lane drives nonzero operands.
   assign a_m     = ready ? a : '0;
   assign b_m     = ready ? b : '0;
   assign c_m     = ready ? c : '0;
   assign rsp_hit = tag_vld && (tag_id == ID);
endmodule

module mac_rr_scheduler #(
   parameter int N_REQ         = 4,
   parameter int SIZE_REG      = 8,
   parameter int SIZE_DATA_OUT = 16,
   parameter int LATENCY       = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      flush,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*SIZE_REG-1:0] req_a,
   input  logic [N_REQ*SIZE_REG-1:0] req_b,
   input  logic [N_REQ*SIZE_REG-1:0] req_c,
   output logic [SIZE_REG-1:0]       mac_a,
   output logic [SIZE_REG-1:0]       mac_b,
   output logic [SIZE_REG-1:0]       mac_c,
   input  logic [SIZE_DATA_OUT-1:0]  mac_data_out,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [SIZE_DATA_OUT-1:0]  rsp_data,
   output logic                      busy,
   output logic                      flush_done
);
   localparam int IDW = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                        state, state_nxt;
   logic                          fd_nxt;
   logic [IDW-1:0]                ptr;
   logic                          found;
   logic [IDW-1:0]                gnt_id;
   logic [IDW:0]                  cand;

   logic [LATENCY:0]              vld_pipe;
   logic [LATENCY:0][IDW-1:0]     id_pipe;

   logic [N_REQ-1:0][SIZE_REG-1:0] a_m, b_m, c_m;
   logic [SIZE_REG-1:0]            a_sel, b_sel, c_sel;
   logic [N_REQ-1:0]               rsp_hit;

   // Search order starts just past the last winner; first valid requester wins.
   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      cand   = '0;
      if (state == S_RUN) begin
         for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
               found  = 1'b1;
               gnt_id = cand[IDW-1:0];
            end
         end
      end
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      mac_rr_lane #(.SIZE_REG(SIZE_REG), .IDW(IDW), .IDX(i)) u_lane (
         .found   (found),
         .gnt_id  (gnt_id),
         .a       (req_a[i*SIZE_REG +: SIZE_REG]),
         .b       (req_b[i*SIZE_REG +: SIZE_REG]),
         .c       (req_c[i*SIZE_REG +: SIZE_REG]),
         .tag_vld (vld_pipe[LATENCY]),
         .tag_id  (id_pipe[LATENCY]),
         .ready   (req_ready[i]),
         .a_m     (a_m[i]),
         .b_m     (b_m[i]),
         .c_m     (c_m[i]),
         .rsp_hit (rsp_hit[i])
      );
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      c_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         a_sel = a_sel | a_m[i];
         b_sel = b_sel | b_m[i];
         c_sel = c_sel | c_m[i];
      end
   end

   assign busy = (|vld_pipe) | (|rsp_valid);

   always_comb begin
      state_nxt = state;
      fd_nxt    = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (flush) state_nxt = S_DRAIN;
         S_DRAIN: if (!busy) begin
            state_nxt = S_IDLE;
            fd_nxt    = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // The tag pipe is one stage longer than the MAC so its head lines up with the
   // cycle in which mac_data_out holds that op's result.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= IDW'(N_REQ-1);
         vld_pipe   <= '0;
         id_pipe    <= '0;
         mac_a      <= '0;
         mac_b      <= '0;
         mac_c      <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= fd_nxt;
         vld_pipe   <= {vld_pipe[LATENCY-1:0], found};
         id_pipe    <= {id_pipe[LATENCY-1:0], gnt_id};
         if (found) begin
            ptr   <= gnt_id;
            mac_a <= a_sel;
            mac_b <= b_sel;
            mac_c <= c_sel;
         end
         rsp_valid <= rsp_hit;
         if (vld_pipe[LATENCY]) rsp_data <= mac_data_out;
      end
   end
endmodule
